// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: start/annul handshake, pipeline stall and HI/LO write.
// Optional `DIV_ZERO_BYPASS_EN` retires a zero-divisor divide in EX without starting the divider.
module div_issue_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_div_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN1, DRAIN2} state_t;

  state_t      r_state;
  logic        r_flush_drain;
  logic        r_signed;
  logic [31:0] r_op1;
  logic [31:0] r_op2;

  logic w_live;
  logic w_bypass;
  logic w_issue;
  logic w_done;

  assign w_live = ex_div_i & ~flush_i;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_bypass = w_live & (ex_rt_i == 32'd0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_issue = (r_state == IDLE) & w_live & ~w_bypass;
  assign w_done  = (r_state == BUSY) & div_ready_i & ~flush_i;

  // A flushed divide may sit in its end state (zero divisor), so it gets an extra start-low cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_flush_drain <= 1'b0;
      r_signed      <= 1'b0;
      r_op1         <= 32'd0;
      r_op2         <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state  <= BUSY;
            r_signed <= ex_signed_i;
            r_op1    <= ex_rs_i;
            r_op2    <= ex_rt_i;
          end
        end
        BUSY: begin
          if (flush_i) begin
            r_state       <= DRAIN1;
            r_flush_drain <= 1'b1;
          end else if (div_ready_i) begin
            r_state       <= DRAIN1;
            r_flush_drain <= 1'b0;
          end
        end
        DRAIN1: begin
          r_state <= r_flush_drain ? DRAIN2 : IDLE;
        end
        DRAIN2: begin
          r_state       <= IDLE;
          r_flush_drain <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    div_start_o  = 1'b0;
    div_annul_o  = 1'b0;
    div_signed_o = 1'b0;
    div_op1_o    = 32'd0;
    div_op2_o    = 32'd0;
    hilo_we_o    = 1'b0;
    hi_o         = 32'd0;
    lo_o         = 32'd0;
    case (r_state)
      IDLE: begin
        div_start_o = w_issue;
        hilo_we_o   = w_bypass;
        if (ex_div_i) begin
          div_signed_o = ex_signed_i;
          div_op1_o    = ex_rs_i;
          div_op2_o    = ex_rt_i;
        end
      end
      BUSY: begin
        // Operands stay on the latched values: the divider re-reads sign bits at its final fixup.
        div_start_o  = ~flush_i;
        div_annul_o  = flush_i;
        div_signed_o = r_signed;
        div_op1_o    = r_op1;
        div_op2_o    = r_op2;
        hilo_we_o    = w_done;
        if (w_done) begin
          hi_o = div_result_i[63:32];
          lo_o = div_result_i[31:0];
        end
      end
      DRAIN1, DRAIN2: begin
        div_annul_o = r_flush_drain;
      end
      default: begin
        div_start_o = 1'b0;
      end
    endcase
  end

  assign stall_req_o = w_live & ~w_done & ~((r_state == IDLE) & w_bypass);

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

EX-stage initiator for the multi-cycle divider. Detects a DIV/DIVU in EX, drives the divider's start/annul/operand handshake, and holds the pipeline stalled until the result returns. It presents HI (remainder) and LO (quotient) with a write-enable to the EX/MEM register, and guarantees that the divider is back in its idle state before the next request is issued.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ex_div_i  in  1  valid DIV/DIVU in EX this cycle
- ex_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_rs_i  in  32  dividend
- ex_rt_i  in  32  divisor
- flush_i  in  1  EX flush (exception or branch kill)
- div_ready_i  in  1  divider result valid
- div_result_i  in  64  {remainder, quotient}
- div_start_o  out  1  divider start, level; held high until ready is seen
- div_annul_o  out  1  divider cancel
- div_signed_o  out  1  signed divide
- div_op1_o  out  32  dividend to divider
- div_op2_o  out  32  divisor to divider
- stall_req_o  out  1  freeze IF/ID/EX
- hilo_we_o  out  1  write HI/LO this cycle
- hi_o  out  32  remainder
- lo_o  out  32  quotient

## Operation
- States: IDLE, BUSY, DRAIN1, DRAIN2.
- IDLE: start_o = ex_div_i & ~flush_i; op1/op2/signed driven directly from ex_*; the same values are latched. If start_o, go to BUSY.
- BUSY: start_o = 1; operands driven from latches and held stable (the divider re-reads the sign bits at its final fixup).
  - div_ready_i & ~flush_i: hilo_we_o = 1, hi_o = div_result_i[63:32], lo_o = div_result_i[31:0], stall released this cycle. Go to DRAIN1 with a drain length of 1.
  - flush_i: start_o = 0, annul_o = 1, no HI/LO write. Go to DRAIN1 with a drain length of 2. Flush wins over a simultaneous ready.
- DRAIN1/DRAIN2: start_o = 0. The divider needs start low while it is in its end state in order to return to idle. After a normal completion, DRAIN1 goes to IDLE. After a flush, DRAIN1 goes to DRAIN2, then to IDLE, which covers the divide-by-zero path. annul_o = 1 throughout a flush drain.
- stall_req_o = ex_div_i & ~flush_i & ~(BUSY & div_ready_i). A div arriving during DRAIN stalls and is issued from IDLE.
- hi_o and lo_o are 0 whenever hilo_we_o = 0.
- Result widths and signs come from the divider unchanged; no extra sign fixup here.

## Timing
- All outputs are combinational from registered state plus inputs.
- Reset values: state IDLE, latches 0. In IDLE with ex_div_i = 0, every output is 0.
- Nominal latency: ready is first high 35 cycles after the first start cycle (nonzero divisor), or 3 cycles (zero divisor). The controller waits on ready_i and never counts cycles.
- A stall of N cycles means the div retires in EX on the ready cycle. Back-to-back divs have a minimum start-to-start spacing of latency + 2 cycles (ready cycle, then one drain cycle).
- Reset mid-operation: the controller returns to IDLE on the same edge as the divider; no write occurs.
- A flush in IDLE suppresses start; no state change.

## Configuration
- DIV_ZERO_BYPASS_EN:
  - Defined: in IDLE, when ex_rt_i == 0, the divider is not started. hilo_we_o = 1 with hi_o = lo_o = 0, and there is no stall that cycle (same result values as the divider produces).
  - Undefined: a zero divisor goes through the divider with a 3-cycle latency.

## Test plan
- DIV 0xFFFFFFF9 / 2 (signed) -> stall until ready; hilo_we_o pulse with lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; start_o low on the next cycle.
- DIVU 100 / 7 -> lo_o = 14, hi_o = 2; stall deasserts the same cycle as ready; one DRAIN cycle.
- Two back-to-back DIVU (100/7, then 9/3) -> the second start_o rises exactly 2 cycles after the first ready; results 14/2, then 3/0.
- Flush 10 cycles after start -> annul_o = 1, start_o = 0, no hilo_we_o; 2 drain cycles; a following DIVU 8/2 gives lo_o = 4.
- Divisor 0: with the macro undefined, ready after 3 cycles and hi_o = lo_o = 0. With DIV_ZERO_BYPASS_EN defined, same-cycle write and div_start_o never asserted.
- resetn low for 1 cycle mid-BUSY -> next cycle state IDLE, all outputs 0; a subsequent DIV 20 / 0xFFFFFFFB gives lo_o = 0xFFFFFFFC, hi_o = 0.
